// File: rtl/sar_search_if.sv
// Handshake and comparator bundle for the successive-approximation search.
// The master side requests searches and closes the loop through an external
// comparator (ge); the slave side is the search engine itself.
interface sar_search_if #(
  parameter int BITS = 8
);
  logic            start;
  logic            ge;
  logic [BITS-1:0] guess;
  logic            busy;
  logic            done;
  logic [BITS-1:0] result;

  modport master (
    output start,
    output ge,
    input  guess,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  ge,
    output guess,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search engine. One trial bit per TEST cycle from
// MSB down to LSB; the external comparator answers "target >= guess" in the
// same cycle, so a search always takes exactly BITS TEST cycles followed by a
// single DONE cycle. result only moves on the final trial or on reset.
module sar_search #(
  parameter int BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BITS-1:0] MSB_MASK = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] LSB_MASK = {{(BITS-1){1'b0}}, 1'b1};

  state_t          state_reg, state_next;
  logic [BITS-1:0] acc_reg, acc_next;
  logic [BITS-1:0] mask_reg, mask_next;
  logic [BITS-1:0] result_reg, result_next;

  logic            in_test;
  logic [BITS-1:0] guess_w;

  // State, accumulator, trial mask and published result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mask_reg   <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mask_reg   <= mask_next;
      result_reg <= result_next;
    end
  end

  // Next-state logic: accept a request in IDLE, keep or drop one trial bit
  // per TEST cycle, publish the accumulator on the LSB trial.
  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mask_next   = mask_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = TEST;
          acc_next   = '0;
          mask_next  = MSB_MASK;
        end
      end
      TEST: begin
        if (bus.ge) begin
          acc_next = acc_reg | mask_reg;
        end
        if (mask_reg == LSB_MASK) begin
          // Final trial: include this cycle's bit in the published value.
          result_next = bus.ge ? (acc_reg | mask_reg) : acc_reg;
          state_next  = DONE;
        end else begin
          mask_next = mask_reg >> 1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_test = (state_reg == TEST);

  // Candidate is the kept bits plus the bit under trial, forced to zero
  // outside TEST so the comparator sees a quiet bus when idle.
  for (genvar gi = 0; gi < BITS; gi++) begin : g_guess
    assign guess_w[gi] = in_test & (acc_reg[gi] | mask_reg[gi]);
  end

  assign bus.guess  = guess_w;
  assign bus.busy   = in_test;
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: three instances (8, 2 and 16 bits) each closed
// through a behavioural comparator. A timeline model predicts every output
// every cycle; directed searches pin the model with hand-computed values.
module tb_sar_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v  [3];
  logic [31:0] tgt_v    [3];
  logic [31:0] guess_v  [3];
  logic [31:0] result_v [3];
  logic        busy_v   [3];
  logic        done_v   [3];

  sar_search_if #(.BITS(8))  bus8 ();
  sar_search_if #(.BITS(2))  bus2 ();
  sar_search_if #(.BITS(16)) bus16 ();

  sar_search #(.BITS(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  sar_search #(.BITS(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
  sar_search #(.BITS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  assign bus8.start  = start_v[0];
  assign bus2.start  = start_v[1];
  assign bus16.start = start_v[2];
  assign bus8.ge     = (tgt_v[0] >= 32'(bus8.guess));
  assign bus2.ge     = (tgt_v[1] >= 32'(bus2.guess));
  assign bus16.ge    = (tgt_v[2] >= 32'(bus16.guess));

  assign guess_v[0]  = 32'(bus8.guess);
  assign guess_v[1]  = 32'(bus2.guess);
  assign guess_v[2]  = 32'(bus16.guess);
  assign result_v[0] = 32'(bus8.result);
  assign result_v[1] = 32'(bus2.result);
  assign result_v[2] = 32'(bus16.result);
  assign busy_v[0]   = bus8.busy;
  assign busy_v[1]   = bus2.busy;
  assign busy_v[2]   = bus16.busy;
  assign done_v[0]   = bus8.done;
  assign done_v[1]   = bus2.done;
  assign done_v[2]   = bus16.done;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bw(input int i);
    case (i)
      0:       return 8;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  // Timeline model: step -1 idle, 0..B-1 = trial number, B = done cycle.
  // A binary search against a fixed target keeps exactly the target's top
  // bits, so trial s proposes target's top s bits plus bit B-1-s, and the
  // answer is the target itself.
  int          m_step [3];
  logic [31:0] m_tgt  [3];
  logic [31:0] m_res  [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_step[i] <= -1;
        m_res[i]  <= 32'd0;
      end else if (m_step[i] == -1) begin
        if (start_v[i]) begin
          m_step[i] <= 0;
          m_tgt[i]  <= tgt_v[i];
        end
      end else if (m_step[i] < bw(i)) begin
        m_step[i] <= m_step[i] + 1;
        if (m_step[i] == bw(i) - 1) m_res[i] <= m_tgt[i];
      end else begin
        m_step[i] <= -1;
      end
    end
  end

  function automatic logic [31:0] exp_guess(input int i);
    int b;
    int s;
    b = bw(i);
    s = m_step[i];
    if (s < 0 || s >= b) return 32'd0;
    return ((m_tgt[i] >> (b - s)) << (b - s)) | (32'd1 << (b - 1 - s));
  endfunction

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy%0d", bw(i)), 32'(busy_v[i]),
            32'(m_step[i] >= 0 && m_step[i] < bw(i)));
        chk($sformatf("done%0d", bw(i)), 32'(done_v[i]), 32'(m_step[i] == bw(i)));
        chk($sformatf("guess%0d", bw(i)), guess_v[i], exp_guess(i));
        chk($sformatf("result%0d", bw(i)), result_v[i], m_res[i]);
      end
    end
  end

  int          gq[$];
  int          done_cyc;
  int          busy_cnt;
  logic [31:0] res_cap;

  // Runs one search from IDLE (called #1 after a rising edge); records the
  // guess sequence, the cycle of done relative to the start edge, and checks
  // that result holds its previous value while busy.
  task automatic search(input int i, input logic [31:0] t, input logic [31:0] hold);
    gq.delete();
    done_cyc = 0;
    busy_cnt = 0;
    res_cap  = 32'hffff_ffff;
    tgt_v[i]   = t;
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy_v[i]) begin
        gq.push_back(int'(guess_v[i]));
        busy_cnt++;
        chk("result_hold", result_v[i], hold);
      end
      if (done_v[i]) begin
        done_cyc = c;
        res_cap  = result_v[i];
        break;
      end
      @(posedge clk); #1;
    end
    if (done_cyc == 0) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic settle(input int i);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy_v[i] && !done_v[i]) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  int          lit170 [8];
  logic [31:0] prev;
  int          dn;
  int          bc;
  logic [31:0] t;

  initial begin
    lit170 = '{128, 192, 160, 176, 168, 172, 170, 171};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      tgt_v[i]   = 32'd0;
    end
    start_v[0] = 1'b1;   // rst must win over start
    tgt_v[0]   = 32'd170;
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_guess", guess_v[0], 32'd0);
    chk("rst_result", result_v[0], 32'd0);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Target 170: literal guess sequence, done in cycle 9, result 170.
    search(0, 32'd170, 32'd0);
    chk("g170_len", 32'(gq.size()), 32'd8);
    for (int k = 0; k < 8 && k < gq.size(); k++)
      chk($sformatf("g170_%0d", k), 32'(gq[k]), 32'(lit170[k]));
    chk("done_cycle", 32'(done_cyc), 32'd9);
    chk("res170", res_cap, 32'd170);
    chk("busy_cnt8", 32'(busy_cnt), 32'd8);

    // Target 0: every trial rejected.
    search(0, 32'd0, 32'd170);
    for (int k = 0; k < 8 && k < gq.size(); k++)
      chk($sformatf("g0_%0d", k), 32'(gq[k]), 32'd128 >> k);
    chk("res0", res_cap, 32'd0);

    // Target 255: every trial kept.
    search(0, 32'd255, 32'd0);
    chk("res255", res_cap, 32'd255);
    chk("g255_last", 32'(gq[gq.size()-1]), 32'd255);

    // start held high: one search per 10 cycles.
    tgt_v[0]   = 32'd99;
    start_v[0] = 1'b1;
    dn = 0;
    bc = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_v[0]) dn++;
      if (busy_v[0]) bc++;
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0;
    chk("held_dones", 32'(dn), 32'd3);
    chk("held_busy", 32'(bc), 32'd24);
    settle(0);

    // Reset on the 4th trial of a 170 search aborts without done.
    tgt_v[0]   = 32'd170;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy_v[0]), 32'd1);
    chk("abort_guess_pre", guess_v[0], 32'd176);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_guess", guess_v[0], 32'd0);
    chk("abort_result", result_v[0], 32'd0);
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done_v[0]) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    @(posedge clk); #1;
    search(0, 32'd170, 32'd0);
    chk("res170_after_abort", res_cap, 32'd170);

    // Back-to-back: 37 then 200, 37 held throughout the second search.
    search(0, 32'd37, 32'd170);
    chk("res37", res_cap, 32'd37);
    search(0, 32'd200, 32'd37);
    chk("res200", res_cap, 32'd200);
    chk("done_cycle200", 32'(done_cyc), 32'd9);

    // Random targets on the 2-bit and 16-bit instances.
    prev = 32'd0;
    for (int n = 0; n < 1000; n++) begin
      t = 32'($urandom_range(0, 3));
      search(1, t, prev);
      chk("res2", res_cap, t);
      chk("busy_cnt2", 32'(busy_cnt), 32'd2);
      prev = t;
    end
    prev = 32'd0;
    for (int n = 0; n < 1000; n++) begin
      t = 32'($urandom_range(0, 65535));
      search(2, t, prev);
      chk("res16", res_cap, t);
      chk("busy_cnt16", 32'(busy_cnt), 32'd16);
      prev = t;
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
